// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// Result-capture FIFO that sits behind the ALU. Each rising edge of op_done
// stores the 64-bit result pair {result_2, result_1} as one entry. A consumer
// drains the entries through a pop request with a one-cycle read latency.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   op_done    ALU completion level; only its rising edge pushes an entry
//   result_2/1 ALU upper/lower result words, sampled on the push cycle
//   op_clear   synchronous flush shared with the ALU; overrides push and pop
//   rd_en      pop request; ignored while empty
//   rd_data_2/1 popped upper/lower words, held between pops
//   rd_valid   one-cycle strobe, high the cycle after an accepted pop
//   empty/full occupancy flags derived directly from count
//   count      occupancy, 0..DEPTH
//   overflow   sticky flag: a result was dropped while full
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_done,
  input  logic [31:0]   result_2,
  input  logic [31:0]   result_1,
  input  logic          op_clear,
  input  logic          rd_en,
  output logic [31:0]   rd_data_2,
  output logic [31:0]   rd_data_1,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [63:0]   mem_q [DEPTH];

  logic          done_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [63:0]   rd_data_q, rd_data_d;

  logic          push, pop, wr_en;
  logic          empty_w, full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_MAX);

  always_comb begin
    push       = op_done & ~done_q;
    pop        = rd_en & ~empty_w;
    // A push while full is still accepted when a pop frees the slot in the
    // same cycle; the pop reads the oldest entry before it is overwritten.
    wr_en      = push & (~full_w | pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (op_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_valid_d = 1'b1;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (push && !wr_en) begin
        overflow_d = 1'b1;
      end
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // done_q keeps tracking op_done through a clear so a level still high
      // afterwards is not mistaken for a new completion.
      done_q     <= op_done;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en && !op_clear) begin
      mem_q[wr_ptr_q] <= {result_2, result_1};
    end
  end

  assign rd_data_2 = rd_data_q[63:32];
  assign rd_data_1 = rd_data_q[31:0];
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: directed stimulus with a queue scoreboard.
module tb_alu_result_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          op_done;
  logic [31:0]   result_2;
  logic [31:0]   result_1;
  logic          op_clear;
  logic          rd_en;
  logic [31:0]   rd_data_2;
  logic [31:0]   rd_data_1;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  // Reference state kept by the bench
  logic [63:0] sb[$];
  int          m_cnt;
  logic        m_ovf;
  logic        m_done;
  logic        exp_rv;
  logic [63:0] m_rd;

  alu_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_done   (op_done),
    .result_2  (result_2),
    .result_1  (result_1),
    .op_clear  (op_clear),
    .rd_en     (rd_en),
    .rd_data_2 (rd_data_2),
    .rd_data_1 (rd_data_1),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    sb.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
    exp_rv = 1'b0;
    m_rd   = '0;
  endtask

  // Advance one clock with the currently driven inputs and check all outputs.
  task automatic cycle();
    logic push_r, pop_r;
    push_r = op_done & ~m_done;
    pop_r  = rd_en & (m_cnt != 0);
    if (op_clear) begin
      sb.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      exp_rv = 1'b0;
    end else begin
      exp_rv = pop_r;
      if (pop_r) m_rd = sb.pop_front();
      if (push_r) begin
        if (m_cnt < DEPTH || pop_r) begin
          sb.push_back({result_2, result_1});
          if (!pop_r) m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (pop_r) begin
        m_cnt--;
      end
    end
    m_done = op_done;
    @(posedge clk);
    #1;
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_rv});
    chk("rd_data",  {rd_data_2, rd_data_1}, m_rd);
    chk("count",    {60'd0, count}, 64'(m_cnt));
    chk("empty",    {63'd0, empty}, {63'd0, (m_cnt == 0)});
    chk("full",     {63'd0, full},  {63'd0, (m_cnt == DEPTH)});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
  endtask

  task automatic do_op(input logic [31:0] r2, input logic [31:0] r1);
    result_2 = r2;
    result_1 = r1;
    op_done  = 1'b1;
    cycle();
    cycle();
    op_done  = 1'b0;
    cycle();
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rd_en = 1'b0;
    cycle();
  endtask

  initial begin
    reset_n  = 1'b0;
    op_done  = 1'b0;
    result_2 = '0;
    result_1 = '0;
    op_clear = 1'b0;
    rd_en    = 1'b0;
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full",  {63'd0, full}, 64'd0);
    chk("rst_ovf",   {63'd0, overflow}, 64'd0);
    chk("rst_rv",    {63'd0, rd_valid}, 64'd0);
    chk("rst_data",  {rd_data_2, rd_data_1}, 64'd0);
    reset_n = 1'b1;

    // 1: pops while empty are ignored
    rd_en = 1'b1;
    repeat (3) cycle();
    rd_en = 1'b0;
    cycle();
    chk("t1_data", {rd_data_2, rd_data_1}, 64'd0);

    // 2: three completions, op_done held two cycles each
    do_op(32'd0, 32'd10);
    do_op(32'd0, 32'hFFFF_FFF6);
    do_op(32'd1, 32'd5);
    chk("t2_count", {60'd0, count}, 64'd3);
    drain(3);
    chk("t2_last", {rd_data_2, rd_data_1}, {32'd1, 32'd5});
    chk("t2_empty", {63'd0, empty}, 64'd1);

    // 3: fill, then one push too many
    for (int i = 1; i <= 8; i++) do_op(32'd0, 32'(i));
    do_op(32'd0, 32'd9);
    chk("t3_full",  {63'd0, full}, 64'd1);
    chk("t3_count", {60'd0, count}, 64'd8);
    chk("t3_ovf",   {63'd0, overflow}, 64'd1);
    drain(8);
    chk("t3_last", {rd_data_2, rd_data_1}, 64'd8);

    // 4: simultaneous push and pop while full
    for (int i = 0; i < 8; i++) do_op(32'd0, 32'h100 + 32'(i));
    result_2 = 32'd0;
    result_1 = 32'hAA;
    op_done  = 1'b1;
    rd_en    = 1'b1;
    cycle();
    chk("t4_oldest", {rd_data_2, rd_data_1}, 64'h100);
    chk("t4_count",  {60'd0, count}, 64'd8);
    chk("t4_ovf",    {63'd0, overflow}, 64'd1);
    op_done = 1'b0;
    rd_en   = 1'b0;
    cycle();
    drain(8);
    chk("t4_last", {rd_data_2, rd_data_1}, 64'hAA);

    // 5: simultaneous push and pop while empty
    result_1 = 32'h55;
    op_done  = 1'b1;
    rd_en    = 1'b1;
    cycle();
    chk("t5_rv",    {63'd0, rd_valid}, 64'd0);
    chk("t5_count", {60'd0, count}, 64'd1);
    op_done = 1'b0;
    rd_en   = 1'b0;
    cycle();
    drain(1);
    chk("t5_data", {rd_data_2, rd_data_1}, 64'h55);

    // 6: clear while op_done high, then reset mid-drain
    for (int i = 0; i < 4; i++) do_op(32'hC0DE, 32'(i));
    result_1 = 32'h77;
    op_done  = 1'b1;
    op_clear = 1'b1;
    cycle();
    chk("t6_clr_count", {60'd0, count}, 64'd0);
    chk("t6_clr_ovf",   {63'd0, overflow}, 64'd0);
    chk("t6_clr_empty", {63'd0, empty}, 64'd1);
    op_clear = 1'b0;
    cycle();
    chk("t6_nopush", {60'd0, count}, 64'd0);
    op_done = 1'b0;
    cycle();
    do_op(32'd2, 32'd3);
    chk("t6_newpush", {60'd0, count}, 64'd1);
    do_op(32'd4, 32'd5);
    do_op(32'd6, 32'd7);
    rd_en = 1'b1;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_count", {60'd0, count}, 64'd0);
    chk("t6_rst_rv",    {63'd0, rd_valid}, 64'd0);
    chk("t6_rst_empty", {63'd0, empty}, 64'd1);
    rd_en = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();
    do_op(32'd8, 32'd9);
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
